// File: rtl/servo_pkg.sv
// Shared definitions for the servo ramp controller: FSM state encoding,
// default frame/duty constants and the duty clamp helper.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } servo_state_e;

  localparam int DEF_PERIOD   = 40;
  localparam int DEF_DUTY_MIN = 2;
  localparam int DEF_DUTY_MAX = 4;

  // Clamp a requested duty into [lo, hi]; lo <= hi is assumed.
  function automatic logic [31:0] clamp_duty(input logic [31:0] value,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
    logic [31:0] res;
    res = value;
    if (value < lo) begin
      res = lo;
    end else if (value > hi) begin
      res = hi;
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_frame_gen.sv
// PWM frame generator: free-running period counter, per-frame duty latch and
// registered servo pin. The duty is captured only at the frame boundary so a
// frame is never cut short or stretched by a mid-frame duty update.
module servo_frame_gen
  import servo_pkg::*;
#(
  parameter int PERIOD     = DEF_PERIOD,
  parameter int W          = 32,
  parameter int RESET_DUTY = DEF_DUTY_MIN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] duty_i,
  output logic         frame_end_o,
  output logic         servo_o
);

  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] period_cnt_q;
  logic [W-1:0]  duty_latched_q;
  logic          servo_q;

  assign frame_end_o = (period_cnt_q == CW'(PERIOD - 1));
  assign servo_o     = servo_q;

  // Period counter, frame-boundary duty latch and registered PWM compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_q   <= '0;
      duty_latched_q <= W'(RESET_DUTY);
      servo_q        <= 1'b0;
    end else begin
      servo_q <= (W'(period_cnt_q) < duty_latched_q);
      if (frame_end_o) begin
        period_cnt_q   <= '0;
        duty_latched_q <= duty_i;
      end else begin
        period_cnt_q <= period_cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Slew-rate-limited servo position controller. Commands arrive over a
// valid/ready handshake, are clamped to the legal duty range, and the applied
// duty walks toward the target by at most STEP once every UPDATE_PERIODS frames.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | duty equals target, nothing to do (hold is ignored)
//   ST_RAMP | stepping duty toward target on each step_tick
//   ST_HOLD | ramp frozen by hold; frames keep running at current duty
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int CLK_FREQ       = 25_000_000,
  parameter int PERIOD         = DEF_PERIOD,
  parameter int DUTY_MIN       = DEF_DUTY_MIN,
  parameter int DUTY_MAX       = DEF_DUTY_MAX,
  parameter int STEP           = 1,
  parameter int UPDATE_PERIODS = 5,
  parameter int W              = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_target,
  input  logic         hold,
  output logic [W-1:0] duty_cycle,
  output logic         at_target,
  output logic         clamp_err,
  output logic         servo_out
);

  if (CLK_FREQ <= 0 || PERIOD < 2 || DUTY_MIN > DUTY_MAX || DUTY_MAX >= PERIOD ||
      STEP < 1 || UPDATE_PERIODS < 1) begin : g_param_check
    $error("servo_ramp_ctrl: illegal parameter combination");
  end

  localparam int FW = (UPDATE_PERIODS > 1) ? $clog2(UPDATE_PERIODS) : 1;
  localparam logic [W-1:0]  MIN_W    = W'(DUTY_MIN);
  localparam logic [W-1:0]  STEP_W   = W'(STEP);
  localparam logic [FW-1:0] FRAME_LAST = FW'(UPDATE_PERIODS - 1);

  servo_state_e  state_q;
  logic          cmd_ready_q;
  logic [W-1:0]  target_q;
  logic [W-1:0]  target_d;
  logic [W-1:0]  duty_q;
  logic [W-1:0]  duty_step_d;
  logic          step_done;
  logic          clamp_err_q;
  logic          at_target_q;
  logic [FW-1:0] frame_cnt_q;
  logic          frame_end;
  logic          step_tick;
  logic          accept;

  assign accept     = cmd_valid & cmd_ready_q;
  assign target_d   = W'(clamp_duty(32'(cmd_target), 32'(DUTY_MIN), 32'(DUTY_MAX)));
  assign step_tick  = frame_end & (frame_cnt_q == FRAME_LAST);

  assign cmd_ready  = cmd_ready_q;
  assign duty_cycle = duty_q;
  assign at_target  = at_target_q;
  assign clamp_err  = clamp_err_q;

  servo_frame_gen #(
    .PERIOD     (PERIOD),
    .W          (W),
    .RESET_DUTY (DUTY_MIN)
  ) u_frame_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .duty_i      (duty_q),
    .frame_end_o (frame_end),
    .servo_o     (servo_out)
  );

  // Handshake, target capture, clamp flag and the lagging at_target compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q <= 1'b0;
      target_q    <= MIN_W;
      clamp_err_q <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      cmd_ready_q <= 1'b1;
      clamp_err_q <= accept & (target_d != cmd_target);
      at_target_q <= (duty_q == target_q);
      if (accept) begin
        target_q <= target_d;
      end
    end
  end

  // Frame counter that paces the ramp; runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_end) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_q <= '0;
      end else begin
        frame_cnt_q <= frame_cnt_q + FW'(1);
      end
    end
  end

  // Next duty one step toward target; compare first so unsigned math never wraps.
  always_comb begin
    duty_step_d = duty_q;
    step_done   = 1'b0;
    if (target_q >= duty_q) begin
      if ((target_q - duty_q) <= STEP_W) begin
        duty_step_d = target_q;
        step_done   = 1'b1;
      end else begin
        duty_step_d = duty_q + STEP_W;
      end
    end else begin
      if ((duty_q - target_q) <= STEP_W) begin
        duty_step_d = target_q;
        step_done   = 1'b1;
      end else begin
        duty_step_d = duty_q - STEP_W;
      end
    end
  end

  // Ramp FSM; hold takes priority over a coincident step_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      duty_q  <= MIN_W;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (target_q != duty_q) begin
            state_q <= ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (hold) begin
            state_q <= ST_HOLD;
          end else if (step_tick) begin
            duty_q <= duty_step_d;
            if (step_done) begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (!hold) begin
            state_q <= (target_q == duty_q) ? ST_IDLE : ST_RAMP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Bench for servo_ramp_ctrl. A cycle-indexed reference model derives frame
// boundaries and step instants from the edge count since reset release and
// applies the slew rule with plain integer arithmetic. Stimulus only changes
// well away from step instants so the model need not track FSM latency.
`timescale 1ns/1ps
module tb_servo_ramp_ctrl;

  localparam int PERIOD   = 40;
  localparam int DUTY_MIN = 2;
  localparam int DUTY_MAX = 4;
  localparam int STEP     = 1;
  localparam int UPD      = 5;
  localparam int W        = 32;
  localparam int TICK     = PERIOD * UPD;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_target = '0;
  logic         hold = 1'b0;
  logic [W-1:0] duty_cycle;
  logic         at_target;
  logic         clamp_err;
  logic         servo_out;

  int n_vec = 0;
  int n_err = 0;

  servo_ramp_ctrl #(
    .CLK_FREQ       (25_000_000),
    .PERIOD         (PERIOD),
    .DUTY_MIN       (DUTY_MIN),
    .DUTY_MAX       (DUTY_MAX),
    .STEP           (STEP),
    .UPDATE_PERIODS (UPD),
    .W              (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .hold       (hold),
    .duty_cycle (duty_cycle),
    .at_target  (at_target),
    .clamp_err  (clamp_err),
    .servo_out  (servo_out)
  );

  always #20 clk = ~clk;

  // ---------------- reference model ----------------
  int      k = 0;              // index of the next rising edge since release
  int      m_duty = DUTY_MIN;
  int      m_target = DUTY_MIN;
  int      m_latched = DUTY_MIN;
  bit      m_ready = 1'b0;
  bit      m_servo = 1'b0;
  bit      m_clamp_err = 1'b0;
  bit      m_at_target = 1'b1;
  bit      m_acc;
  longint  m_req;
  longint  m_clamped;
  int      m_ph;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; m_duty = DUTY_MIN; m_target = DUTY_MIN; m_latched = DUTY_MIN;
      m_ready = 1'b0; m_servo = 1'b0; m_clamp_err = 1'b0; m_at_target = 1'b1;
    end else begin
      m_ph      = k % PERIOD;
      m_acc     = cmd_valid && m_ready;
      m_req     = longint'(cmd_target);
      m_clamped = (m_req < DUTY_MIN) ? DUTY_MIN : (m_req > DUTY_MAX) ? DUTY_MAX : m_req;
      m_at_target = (m_duty == m_target);
      m_servo     = (m_ph < m_latched);
      m_clamp_err = m_acc && (m_clamped != m_req);
      if (m_ph == PERIOD - 1) m_latched = m_duty;
      if ((k % TICK) == TICK - 1 && !hold && m_duty != m_target) begin
        if (m_target > m_duty)
          m_duty = (m_target - m_duty <= STEP) ? m_target : m_duty + STEP;
        else
          m_duty = (m_duty - m_target <= STEP) ? m_target : m_duty - STEP;
      end
      if (m_acc) m_target = int'(m_clamped);
      m_ready = 1'b1;
      k++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0; hold = 1'b0; cmd_target = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance until the next edge lies well clear of a step instant.
  task automatic wait_safe();
    int guard = 0;
    while (!((k % TICK) >= 5 && (k % TICK) <= TICK - 10) && guard < 2 * TICK) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic send(input logic [W-1:0] t);
    cmd_valid = 1'b1; cmd_target = t;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int highs = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset cmd_ready got %b exp 0", cmd_ready); end
    n_vec++; if (duty_cycle !== W'(DUTY_MIN)) begin n_err++; $display("FAIL reset duty got %0d exp %0d", duty_cycle, DUTY_MIN); end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL reset at_target got %b exp 1", at_target); end
    n_vec++; if (servo_out !== 1'b0) begin n_err++; $display("FAIL reset servo_out got %b exp 0", servo_out); end
    n_vec++; if (clamp_err !== 1'b0) begin n_err++; $display("FAIL reset clamp_err got %b exp 0", clamp_err); end
    rst_n = 1'b1;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL release cmd_ready got %b exp 1", cmd_ready); end
      end
      n_vec++; if (servo_out !== m_servo) begin n_err++; $display("FAIL reset_pwm servo_out k=%0d got %b exp %b", k, servo_out, m_servo); end
      if (servo_out === 1'b1) highs++;
    end
    n_vec++; if (highs != 2 * DUTY_MIN) begin n_err++; $display("FAIL reset_pwm highs in 2 frames got %0d exp %0d", highs, 2 * DUTY_MIN); end
  endtask

  task automatic test_ramp();
    int highs = 0;
    int guard = 0;
    do_reset();
    wait_safe();
    send(W'(DUTY_MAX));
    for (int i = 0; i < 2 * TICK + PERIOD; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_vec++; if (at_target !== 1'b0) begin n_err++; $display("FAIL ramp at_target after accept got %b exp 0", at_target); end
      end
      n_vec++; if (duty_cycle !== W'(m_duty)) begin n_err++; $display("FAIL ramp duty k=%0d got %0d exp %0d", k, duty_cycle, m_duty); end
      n_vec++; if (servo_out !== m_servo) begin n_err++; $display("FAIL ramp servo_out k=%0d got %b exp %b", k, servo_out, m_servo); end
      n_vec++; if (at_target !== m_at_target) begin n_err++; $display("FAIL ramp at_target k=%0d got %b exp %b", k, at_target, m_at_target); end
    end
    n_vec++; if (duty_cycle !== W'(DUTY_MAX)) begin n_err++; $display("FAIL ramp final duty got %0d exp %0d", duty_cycle, DUTY_MAX); end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL ramp final at_target got %b exp 1", at_target); end
    while ((k % PERIOD) != 0 && guard < 2 * PERIOD) begin @(negedge clk); guard++; end
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (servo_out === 1'b1) highs++;
    end
    n_vec++; if (highs != DUTY_MAX) begin n_err++; $display("FAIL ramp pwm highs per frame got %0d exp %0d", highs, DUTY_MAX); end
  endtask

  task automatic test_clamp();
    logic [W-1:0] reqs [3];
    int           exp_duty [3];
    bit           exp_clamp [3];
    reqs[0] = W'(9); exp_duty[0] = DUTY_MAX; exp_clamp[0] = 1'b1;
    reqs[1] = W'(0); exp_duty[1] = DUTY_MIN; exp_clamp[1] = 1'b1;
    reqs[2] = W'(3); exp_duty[2] = 3;        exp_clamp[2] = 1'b0;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      wait_safe();
      send(reqs[n]);
      n_vec++; if (clamp_err !== exp_clamp[n]) begin n_err++; $display("FAIL clamp pulse req=%0d got %b exp %b", reqs[n], clamp_err, exp_clamp[n]); end
      @(negedge clk);
      n_vec++; if (clamp_err !== 1'b0) begin n_err++; $display("FAIL clamp pulse width req=%0d got %b exp 0", reqs[n], clamp_err); end
      for (int i = 0; i < 2 * TICK + 10; i++) begin
        @(negedge clk);
        n_vec++; if (duty_cycle !== W'(m_duty)) begin n_err++; $display("FAIL clamp duty k=%0d got %0d exp %0d", k, duty_cycle, m_duty); end
        n_vec++; if (clamp_err !== m_clamp_err) begin n_err++; $display("FAIL clamp clamp_err k=%0d got %b exp %b", k, clamp_err, m_clamp_err); end
        n_vec++; if (at_target !== m_at_target) begin n_err++; $display("FAIL clamp at_target k=%0d got %b exp %b", k, at_target, m_at_target); end
      end
      n_vec++; if (duty_cycle !== W'(exp_duty[n])) begin n_err++; $display("FAIL clamp settled duty req=%0d got %0d exp %0d", reqs[n], duty_cycle, exp_duty[n]); end
    end
  endtask

  task automatic test_retarget();
    bit seen = 1'b0;
    do_reset();
    wait_safe();
    send(W'(DUTY_MAX));
    for (int i = 0; i < TICK + 20 && !seen; i++) begin
      @(negedge clk);
      n_vec++; if (duty_cycle !== W'(m_duty)) begin n_err++; $display("FAIL retarget duty k=%0d got %0d exp %0d", k, duty_cycle, m_duty); end
      if (duty_cycle === W'(DUTY_MIN + STEP)) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL retarget first step timeout got duty %0d exp %0d", duty_cycle, DUTY_MIN + STEP); end
    wait_safe();
    send(W'(DUTY_MIN));
    for (int i = 0; i < TICK + 10; i++) begin
      @(negedge clk);
      n_vec++; if (duty_cycle !== W'(m_duty)) begin n_err++; $display("FAIL retarget duty k=%0d got %0d exp %0d", k, duty_cycle, m_duty); end
      n_vec++; if (at_target !== m_at_target) begin n_err++; $display("FAIL retarget at_target k=%0d got %b exp %b", k, at_target, m_at_target); end
    end
    n_vec++; if (duty_cycle !== W'(DUTY_MIN)) begin n_err++; $display("FAIL retarget final duty got %0d exp %0d", duty_cycle, DUTY_MIN); end
  endtask

  task automatic test_hold();
    do_reset();
    wait_safe();
    send(W'(DUTY_MAX));
    repeat (3) @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 3 * TICK; i++) begin
      @(negedge clk);
      n_vec++; if (duty_cycle !== W'(m_duty)) begin n_err++; $display("FAIL hold duty k=%0d got %0d exp %0d", k, duty_cycle, m_duty); end
      n_vec++; if (servo_out !== m_servo) begin n_err++; $display("FAIL hold servo_out k=%0d got %b exp %b", k, servo_out, m_servo); end
    end
    n_vec++; if (duty_cycle !== W'(DUTY_MIN)) begin n_err++; $display("FAIL hold frozen duty got %0d exp %0d", duty_cycle, DUTY_MIN); end
    wait_safe();
    hold = 1'b0;
    for (int i = 0; i < TICK; i++) begin
      @(negedge clk);
      n_vec++; if (duty_cycle !== W'(m_duty)) begin n_err++; $display("FAIL hold release duty k=%0d got %0d exp %0d", k, duty_cycle, m_duty); end
    end
    n_vec++; if (duty_cycle !== W'(DUTY_MIN + STEP)) begin n_err++; $display("FAIL hold resume duty got %0d exp %0d", duty_cycle, DUTY_MIN + STEP); end
  endtask

  task automatic test_random();
    int act;
    int gap;
    do_reset();
    for (int it = 0; it < 50; it++) begin
      wait_safe();
      act = $urandom_range(0, 4);
      case (act)
        0:       begin cmd_valid = 1'b1; cmd_target = W'($urandom); end
        1, 2, 4: begin cmd_valid = 1'b1; cmd_target = W'($urandom_range(0, 6)); end
        default: hold = ~hold;
      endcase
      gap = $urandom_range(2, 150);
      for (int j = 0; j < gap; j++) begin
        @(negedge clk);
        if (j == 0 && act == 4) cmd_target = W'($urandom_range(0, 6));
        else cmd_valid = 1'b0;
        n_vec++; if (duty_cycle !== W'(m_duty)) begin n_err++; $display("FAIL random duty k=%0d got %0d exp %0d", k, duty_cycle, m_duty); end
        n_vec++; if (servo_out !== m_servo) begin n_err++; $display("FAIL random servo_out k=%0d got %b exp %b", k, servo_out, m_servo); end
        n_vec++; if (at_target !== m_at_target) begin n_err++; $display("FAIL random at_target k=%0d got %b exp %b", k, at_target, m_at_target); end
        n_vec++; if (clamp_err !== m_clamp_err) begin n_err++; $display("FAIL random clamp_err k=%0d got %b exp %b", k, clamp_err, m_clamp_err); end
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_midramp();
    bit seen = 1'b0;
    bit high = 1'b0;
    do_reset();
    wait_safe();
    send(W'(DUTY_MAX));
    for (int i = 0; i < TICK + 20 && !seen; i++) begin
      @(negedge clk);
      if (duty_cycle === W'(DUTY_MIN + STEP)) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL midreset step timeout got duty %0d exp %0d", duty_cycle, DUTY_MIN + STEP); end
    for (int i = 0; i < 2 * PERIOD && !high; i++) begin
      @(negedge clk);
      if (servo_out === 1'b1) high = 1'b1;
    end
    n_vec++; if (!high) begin n_err++; $display("FAIL midreset servo_out never high got %b exp 1", servo_out); end
    #5 rst_n = 1'b0;
    #1;
    n_vec++; if (servo_out !== 1'b0) begin n_err++; $display("FAIL midreset async servo_out got %b exp 0", servo_out); end
    n_vec++; if (duty_cycle !== W'(DUTY_MIN)) begin n_err++; $display("FAIL midreset duty got %0d exp %0d", duty_cycle, DUTY_MIN); end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL midreset at_target got %b exp 1", at_target); end
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL midreset cmd_ready got %b exp 0", cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < TICK + 20; i++) begin
      @(negedge clk);
      n_vec++; if (duty_cycle !== W'(m_duty)) begin n_err++; $display("FAIL midreset idle duty k=%0d got %0d exp %0d", k, duty_cycle, m_duty); end
      n_vec++; if (servo_out !== m_servo) begin n_err++; $display("FAIL midreset servo_out k=%0d got %b exp %b", k, servo_out, m_servo); end
    end
    n_vec++; if (duty_cycle !== W'(DUTY_MIN)) begin n_err++; $display("FAIL midreset final duty got %0d exp %0d", duty_cycle, DUTY_MIN); end
  endtask

  initial begin
    #(60000 * 40);
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_clamp();
    test_retarget();
    test_hold();
    test_random();
    test_reset_midramp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
